key_field_editor: RTL and testbench

// Parametrised key-driven editor for NUM_FIELDS bounded numeric fields (time, date, alarm).

---
 rtl/key_field_editor.sv | 211 +++++++++++++++++++++
 tb/tb_key_field_editor.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_field_editor.sv
// key_field_editor: debounced 5-key pad driving an edit session
// over NUM_FIELDS bounded numeric fields with wrap, cancel and timeout.
module key_field_editor #(
  parameter int NUM_FIELDS   = 3,
  parameter int FIELD_W      = 7,
  parameter int DEBOUNCE     = 20000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000,
  parameter int TIMEOUT      = 1000000,
  localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int VW    = NUM_FIELDS * FIELD_W
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [4:0]       KEY,
  input  logic [VW-1:0]    IN_VALUES,
  input  logic [VW-1:0]    FIELD_MIN,
  input  logic [VW-1:0]    FIELD_MAX,
  input  logic             COMMIT_ACK,
  output logic [VW-1:0]    OUT_VALUES,
  output logic [SEL_W-1:0] FIELD_SEL,
  output logic             EDITING,
  output logic             COMMIT,
  output logic             CANCELLED,
  output logic             TIMED_OUT
);

  localparam int K_DOWN   = 0;
  localparam int K_UP     = 1;
  localparam int K_CANCEL = 2;
  localparam int K_SET    = 3;
  localparam int K_MENU   = 4;

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int DBW  = $clog2(DEBOUNCE + 1);
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT_WAIT
  } state_t;

  logic [4:0]     k_q;
  logic [DBW-1:0] db_cnt;
  logic           armed;
  logic           rep_late;
  logic [RW-1:0]  rep_cnt;
  logic [4:0]     ev_q;
  logic           first_ev;
  logic           rep_ev;
  logic           raw_ev;
  logic           key_chg;

  // Event detection: first stable one-hot sample, then UP/DOWN repeats.
  always_comb begin
    key_chg  = (KEY != k_q);
    first_ev = $onehot(k_q) && (db_cnt == DBW'(DEBOUNCE - 1));
    rep_ev   = armed &&
               (rep_cnt == (rep_late ? RW'(REPEAT_RATE)
                                     : RW'(REPEAT_DELAY)));
    raw_ev   = first_ev || rep_ev;
  end

  // Key sampling, stability counter, repeat timer, event register.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      k_q      <= '0;
      db_cnt   <= '0;
      armed    <= 1'b0;
      rep_late <= 1'b0;
      rep_cnt  <= '0;
      ev_q     <= '0;
    end else begin
      k_q <= KEY;
      if (key_chg)
        db_cnt <= '0;
      else if (db_cnt != DBW'(DEBOUNCE))
        db_cnt <= db_cnt + DBW'(1);
      if (key_chg) begin
        armed    <= 1'b0;
        rep_late <= 1'b0;
        rep_cnt  <= '0;
      end else if (raw_ev) begin
        armed    <= k_q[K_UP] | k_q[K_DOWN];
        rep_late <= rep_ev;
        rep_cnt  <= RW'(1);
      end else if (armed) begin
        rep_cnt <= rep_cnt + RW'(1);
      end
      ev_q <= raw_ev ? k_q : 5'b0;
    end
  end

  state_t             state;
  state_t             state_n;
  logic [VW-1:0]      vals;
  logic [VW-1:0]      vals_n;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_n;
  logic [TW-1:0]      idle;
  logic [TW-1:0]      idle_n;
  logic               cancel_n;
  logic               tmo_n;
  logic [FIELD_W-1:0] cur;
  logic [FIELD_W-1:0] mn;
  logic [FIELD_W-1:0] mx;
  logic [FIELD_W-1:0] up_v;
  logic [FIELD_W-1:0] dn_v;

  // Selected field and its wrapped increment/decrement.
  always_comb begin
    cur = '0;
    mn  = '0;
    mx  = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (sel == SEL_W'(i)) begin
        cur = vals[i*FIELD_W +: FIELD_W];
        mn  = FIELD_MIN[i*FIELD_W +: FIELD_W];
        mx  = FIELD_MAX[i*FIELD_W +: FIELD_W];
      end
    end
    up_v = (cur >= mx) ? mn : cur + FIELD_W'(1);
    dn_v = (cur <= mn) ? mx : cur - FIELD_W'(1);
  end

  // Session next-state and datapath updates.
  always_comb begin
    state_n  = state;
    vals_n   = vals;
    sel_n    = sel;
    idle_n   = idle;
    cancel_n = 1'b0;
    tmo_n    = 1'b0;
    unique case (state)
      IDLE: begin
        vals_n = IN_VALUES;
        if (ev_q[K_SET]) begin
          state_n = EDIT;
          sel_n   = '0;
          idle_n  = '0;
        end
      end
      EDIT: begin
        if (ev_q != 5'b0) begin
          idle_n = '0;
          unique case (1'b1)
            ev_q[K_MENU]:
              sel_n = (sel == SEL_W'(NUM_FIELDS - 1)) ?
                      '0 : sel + SEL_W'(1);
            ev_q[K_UP]:
              for (int i = 0; i < NUM_FIELDS; i++)
                if (sel == SEL_W'(i))
                  vals_n[i*FIELD_W +: FIELD_W] = up_v;
            ev_q[K_DOWN]:
              for (int i = 0; i < NUM_FIELDS; i++)
                if (sel == SEL_W'(i))
                  vals_n[i*FIELD_W +: FIELD_W] = dn_v;
            ev_q[K_SET]:
              state_n = COMMIT_WAIT;
            ev_q[K_CANCEL]: begin
              state_n  = IDLE;
              cancel_n = 1'b1;
            end
            default: ;
          endcase
        end else if (idle == TW'(TIMEOUT - 1)) begin
          state_n  = IDLE;
          cancel_n = 1'b1;
          tmo_n    = 1'b1;
        end else begin
          idle_n = idle + TW'(1);
        end
      end
      COMMIT_WAIT: begin
        if (COMMIT_ACK)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Session state, values and registered status outputs.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state     <= IDLE;
      vals      <= '0;
      sel       <= '0;
      idle      <= '0;
      EDITING   <= 1'b0;
      COMMIT    <= 1'b0;
      CANCELLED <= 1'b0;
      TIMED_OUT <= 1'b0;
    end else begin
      state     <= state_n;
      vals      <= vals_n;
      sel       <= sel_n;
      idle      <= idle_n;
      EDITING   <= (state_n == EDIT);
      COMMIT    <= (state_n == COMMIT_WAIT);
      CANCELLED <= cancel_n;
      TIMED_OUT <= tmo_n;
    end
  end

  assign OUT_VALUES = vals;
  assign FIELD_SEL  = sel;

endmodule

// File: tb/tb_key_field_editor.sv
// tb_key_field_editor: directed scenarios plus random key traffic,
// checked every cycle against a behavioural session model.
module tb_key_field_editor;

  localparam int NF = 3;
  localparam int FW = 7;
  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;
  localparam int TO = 64;

  localparam logic [4:0] DN  = 5'b00001;
  localparam logic [4:0] UP  = 5'b00010;
  localparam logic [4:0] CAN = 5'b00100;
  localparam logic [4:0] SET = 5'b01000;
  localparam logic [4:0] MEN = 5'b10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    key = '0;
  logic [20:0]   in_v;
  logic [20:0]   fmin;
  logic [20:0]   fmax;
  logic          ack = 1'b0;
  logic [20:0]   out_v;
  logic [1:0]    fsel;
  logic          editing;
  logic          commit;
  logic          cancelled;
  logic          timed_out;

  int n_cmp = 0;
  int n_bad = 0;

  key_field_editor #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .DEBOUNCE(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RESETN(rst_n), .KEY(key),
    .IN_VALUES(in_v), .FIELD_MIN(fmin), .FIELD_MAX(fmax),
    .COMMIT_ACK(ack), .OUT_VALUES(out_v), .FIELD_SEL(fsel),
    .EDITING(editing), .COMMIT(commit),
    .CANCELLED(cancelled), .TIMED_OUT(timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               nm, got, want, $time);
    end
  endtask

  // Behavioural model: sessions as plain integers, key events
  // derived from how many consecutive edges a one-hot key was seen.
  int          ms;
  int          mv[NF];
  int          msel;
  int          mquiet;
  bit          mcan;
  bit          mtmo;
  logic [4:0]  prevk;
  int          run;
  logic [4:0]  slot0;
  logic [4:0]  slot1;
  logic [4:0]  act;
  logic [20:0] exp_out;
  bit          seen = 1'b0;

  function automatic bit raw_ev(input logic [4:0] k, input int m);
    if (!$onehot(k)) return 1'b0;
    if (m == DB - 1) return 1'b1;
    if ((k == UP || k == DN) && m >= DB - 1 + RD &&
        ((m - (DB - 1) - RD) % RR) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int v;
    int lo;
    int hi;
    seen = 1'b1;
    mcan = 1'b0;
    mtmo = 1'b0;
    if (!rst_n) begin
      ms = 0;
      msel = 0;
      mquiet = 0;
      for (int i = 0; i < NF; i++) mv[i] = 0;
      prevk = '0;
      run = 0;
      slot0 = '0;
      slot1 = '0;
    end else begin
      act = slot1;
      slot1 = slot0;
      if (key != prevk) run = 0;
      else run++;
      prevk = key;
      slot0 = raw_ev(key, run) ? key : 5'b0;
      case (ms)
        0: begin
          for (int i = 0; i < NF; i++)
            mv[i] = int'(in_v[i*FW +: FW]);
          if (act == SET) begin
            ms = 1;
            msel = 0;
            mquiet = 0;
          end
        end
        1: begin
          if (act != 5'b0) begin
            mquiet = 0;
            v  = mv[msel];
            lo = int'(fmin[msel*FW +: FW]);
            hi = int'(fmax[msel*FW +: FW]);
            if (act == MEN) msel = (msel + 1) % NF;
            else if (act == UP) mv[msel] = (v >= hi) ? lo : v + 1;
            else if (act == DN) mv[msel] = (v <= lo) ? hi : v - 1;
            else if (act == SET) ms = 2;
            else if (act == CAN) begin
              ms = 0;
              mcan = 1'b1;
            end
          end else begin
            mquiet++;
            if (mquiet == TO) begin
              ms = 0;
              mcan = 1'b1;
              mtmo = 1'b1;
            end
          end
        end
        default: if (ack) ms = 0;
      endcase
    end
    for (int i = 0; i < NF; i++)
      exp_out[i*FW +: FW] = mv[i][FW-1:0];
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (seen) begin
      chk("out_values", 32'(out_v), 32'(exp_out));
      chk("field_sel", 32'(fsel), 32'(msel));
      chk("editing", 32'(editing), 32'(ms == 1));
      chk("commit", 32'(commit), 32'(ms == 2));
      chk("cancelled", 32'(cancelled), 32'(mcan));
      chk("timed_out", 32'(timed_out), 32'(mtmo));
    end
  end

  task automatic press(input logic [4:0] k,
                       input int hold,
                       input int gap);
    @(negedge clk);
    key = k;
    repeat (hold) @(negedge clk);
    key = '0;
    repeat (gap) @(negedge clk);
  endtask

  logic [4:0] ktab[11];
  int         hold;

  initial begin
    ktab[0] = MEN;  ktab[1] = SET;  ktab[2] = CAN;
    ktab[3] = UP;   ktab[4] = DN;   ktab[5] = SET;
    ktab[6] = UP;   ktab[7] = DN;   ktab[8] = 5'b0;
    ktab[9] = 5'b00011; ktab[10] = 5'b11000;
    in_v = {7'd0, 7'd59, 7'd23};
    fmin = '0;
    fmax = {7'd59, 7'd59, 7'd23};

    repeat (2) @(negedge clk);
    chk("reset_out", 32'(out_v), 0);
    chk("reset_editing", 32'(editing), 0);
    chk("reset_commit", 32'(commit), 0);
    chk("reset_sel", 32'(fsel), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_track", 32'(out_v), 32'({7'd0, 7'd59, 7'd23}));

    // Bounce: short SET pulses never qualify.
    for (int i = 0; i < 5; i++) begin
      key = SET;
      repeat (2) @(negedge clk);
      key = '0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("bounce_no_edit", 32'(editing), 0);
    key = SET;
    repeat (5) @(posedge clk);
    #1 chk("set_edge5", 32'(editing), 0);
    @(posedge clk);
    #1 chk("set_edge6", 32'(editing), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    key = '0;
    repeat (4) @(negedge clk);

    // Wrap behaviour.
    press(CAN, 6, 3);
    press(SET, 6, 3);
    press(UP, 6, 3);
    chk("up_wrap_f0", 32'(out_v[6:0]), 0);
    press(MEN, 6, 3);
    press(DN, 6, 3);
    press(DN, 6, 3);
    chk("down_f1", 32'(out_v[13:7]), 57);
    chk("sel_1", 32'(fsel), 1);
    press(MEN, 6, 3);
    press(MEN, 6, 3);
    chk("sel_wrap", 32'(fsel), 0);
    press(DN, 6, 3);
    chk("down_wrap_f0", 32'(out_v[6:0]), 23);

    // Auto-repeat: 7 events over a 40-cycle hold.
    press(CAN, 6, 3);
    in_v = {7'd0, 7'd59, 7'd5};
    press(SET, 6, 3);
    press(UP, 40, 4);
    chk("repeat_f0", 32'(out_v[6:0]), 12);

    // Commit handshake.
    press(CAN, 6, 3);
    press(SET, 6, 3);
    press(UP, 6, 3);
    press(SET, 6, 3);
    chk("commit_hi", 32'(commit), 1);
    chk("commit_not_edit", 32'(editing), 0);
    in_v = {7'd1, 7'd2, 7'd3};
    press(UP, 6, 2);
    press(DN, 6, 2);
    press(MEN, 6, 2);
    press(CAN, 6, 2);
    chk("commit_frozen", 32'(out_v), 32'({7'd0, 7'd59, 7'd6}));
    chk("commit_no_cancel", 32'(cancelled), 0);
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 chk("ack_commit_lo", 32'(commit), 0);
    chk("ack_out_held", 32'(out_v), 32'({7'd0, 7'd59, 7'd6}));
    ack = 1'b0;
    @(posedge clk);
    #1 chk("ack_tracks", 32'(out_v), 32'({7'd1, 7'd2, 7'd3}));

    // Cancel pulse.
    press(SET, 6, 3);
    press(UP, 6, 3);
    @(negedge clk);
    key = CAN;
    repeat (5) @(posedge clk);
    #1 chk("cancel_pre", 32'(cancelled), 0);
    @(posedge clk);
    #1 chk("cancel_pulse", 32'(cancelled), 1);
    chk("cancel_idle", 32'(editing), 0);
    @(posedge clk);
    #1 chk("cancel_once", 32'(cancelled), 0);
    chk("cancel_tracks", 32'(out_v), 32'({7'd1, 7'd2, 7'd3}));
    key = '0;
    repeat (3) @(negedge clk);

    // Inactivity timeout.
    key = SET;
    repeat (6) @(posedge clk);
    #1 chk("to_enter", 32'(editing), 1);
    key = '0;
    repeat (63) @(posedge clk);
    #1 chk("to_still_edit", 32'(editing), 1);
    chk("to_not_yet", 32'(timed_out), 0);
    @(posedge clk);
    #1 chk("to_cancel", 32'(cancelled), 1);
    chk("to_timed_out", 32'(timed_out), 1);
    chk("to_idle", 32'(editing), 0);
    @(posedge clk);
    #1 chk("to_once", 32'(timed_out), 0);

    // Reset during COMMIT_WAIT.
    repeat (2) @(negedge clk);
    press(SET, 6, 3);
    press(UP, 6, 3);
    press(SET, 6, 3);
    chk("rst_pre_commit", 32'(commit), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("rst_out", 32'(out_v), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_sel", 32'(fsel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle_track", 32'(out_v), 32'({7'd1, 7'd2, 7'd3}));
    chk("rst_idle_commit", 32'(commit), 0);

    // Random traffic.
    for (int t = 0; t < 160; t++) begin
      if (t == 80) begin
        fmin = {7'd10, 7'd5, 7'd1};
        fmax = {7'd40, 7'd30, 7'd12};
      end
      @(negedge clk);
      key = ktab[$urandom_range(0, 10)];
      hold = int'($urandom_range(1, 40));
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 15) == 0)
          in_v = 21'($urandom);
        ack = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      ack = 1'b0;
    end
    key = '0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
